reg_datapath_param: RTL and testbench
=====================================

Name: reg_datapath_param

Overview:
- Parametrised next-generation register datapath: PC, MAR, MBR, IR, a bank of NACC accumulators, and a registered ALU with an iterative multiplier.
- Sits between the control unit (control word, ALU op, halt) and the external bus.
- Unlike the previous generation, memory accesses use a request/acknowledge handshake with a timeout. A busy/stall output is returned to the control unit.

Parameters:
- DATA_W, 16, width of MBR, ACC, ALU, BR, MR and memory data.
- ADDR_W, 8, width of PC, MAR and memory address; the IR address field is IR[ADDR_W-1:0].
- OPC_W, 8, opcode field width; opcode = IR[DATA_W-1 -: OPC_W].
- NACC, 4, number of accumulators (>=1); select width AW = max(1, clog2(NACC)).
- MEM_TIMEOUT, 15, wait cycles without ack before a transaction is aborted (>=1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_cpu_start  in  1  gates C2; C2 is ignored while low.
- i_ctrl  in  16  control strobes C0..C15 (bit n = Cn).
- i_alu_op  in  4  [3] ALU enable, [2:0] operation.
- i_acc_sel  in  AW  accumulator used by C7/C9/C10/C11/C12.
- i_halt  in  1  forces o_ir_opcode to 0.
- i_mar_inc  in  1  MAR <= MAR+1.
- i_mem_rdata  in  DATA_W  read data.
- i_mem_ack  in  1  transaction complete.
- o_mem_addr  out  ADDR_W  always equals MAR.
- o_mem_wdata  out  DATA_W  always equals MBR.
- o_mem_rd  out  1  read request.
- o_mem_wr  out  1  write request.
- o_busy  out  1  stall; the control unit holds the control word while high.
- o_ir_opcode  out  OPC_W  opcode to the control unit.
- o_flags  out  5  {memerr, N, V, C, Z}.
- o_alu_p  out  DATA_W  ALU P operand (selected ACC).
- o_alu_q  out  DATA_W  ALU Q operand (MBR).
- o_alu_lo  out  DATA_W  BR.
- o_alu_hi  out  DATA_W  MR.

Behaviour:
- Reset: all registers and outputs are 0. The FSM goes to IDLE, the multiplier counter is cleared, and flags are 0 (memerr included).
- Strobes are sampled only when o_busy=0. While busy, i_ctrl, i_alu_op and i_mar_inc are ignored.
- PC:
  - C2 & i_cpu_start: MAR<=PC and PC<=PC+1, wrapping modulo 2^ADDR_W.
  - C3: PC<=MBR[ADDR_W-1:0].
  - C3 has priority over the increment.
- MAR priority: C2 > C8 (MBR[ADDR_W-1:0]) > i_mar_inc. The increment wraps to 0.
- MBR priority: C12 (ACC[sel]) > C15 (IR address field, zero-extended) > C1 (PC, zero-extended).
- C5 (read): MBR is loaded only on read completion.
- C4: IR<=MBR.
- ACC[sel] priority: C11 (MBR) > C9 (BR) > C10 (MR). Unselected accumulators hold their value.
- Memory FSM, states IDLE, RD, WR:
  - IDLE, C5: go to RD, o_mem_rd=1 from the next cycle.
  - IDLE, C13: go to WR, o_mem_wr=1 from the next cycle.
  - C5 and C13 together: read wins; C13 is dropped.
  - RD, i_mem_ack=1: MBR<=i_mem_rdata, return to IDLE, deassert the request the same edge.
  - WR, i_mem_ack=1: return to IDLE.
  - Wait counter increments each RD/WR cycle without ack. When it reaches MEM_TIMEOUT: go to IDLE, set memerr (sticky until reset), leave MBR unchanged.
  - An ack while in IDLE is ignored.
  - Reset mid-transaction drops o_mem_rd/o_mem_wr on the next edge.
- o_busy = (FSM!=IDLE) | multiplier active. It is registered, high from the cycle after launch.
- ALU, enable=1, P=ACC[sel] (C7 not required for the value), Q=MBR:
  - Ops: 0 ADD, 1 SUB (P-Q), 2 AND, 3 OR, 4 NOT P, 5 SHL P by 1, 6 SHR P logical by 1, 7 MPY.
  - Ops 0-6: BR<=result at the next edge, MR<=0.
  - Z = result==0, N = msb.
  - C = carry-out for ADD, borrow for SUB, shifted-out bit for shifts.
  - V = signed overflow for ADD/SUB, 0 otherwise.
- MPY:
  - Unsigned shift-add over DATA_W cycles with o_busy high.
  - {MR,BR} = P*Q at completion, total latency DATA_W+1 edges.
  - Z over the 2*DATA_W product; N = MR msb; C = V = (MR!=0).
- Operands are captured at MPY launch. Changing ACC or MBR mid-multiply has no effect.
- Enable=0: BR, MR and flags hold.
- o_ir_opcode = i_halt ? 0 : IR opcode field (combinational).

Test Plan:
- Reset, then C2 with i_cpu_start=1 and PC=0xFF → MAR=0xFF, PC=0x00. Then C2 with i_cpu_start=0 → no change.
- MAR=0x10, C5, ack after 3 cycles with rdata=0xBEEF → o_mem_rd high for 3 cycles, MBR=0xBEEF, o_busy falls with ack. A strobe C8 during the wait is ignored.
- C13 with no ack → o_mem_wr held 15 cycles, then dropped; o_flags[4]=1 persists across later successful accesses until i_rst.
- ACC1=0x7FFF, MBR=0x0001, op ADD, sel=1 → BR=0x8000, V=1, N=1, C=0, Z=0. Then C9 → ACC1=0x8000, ACC0 unchanged.
- ACC0=0xFFFF, MBR=0xFFFF, op MPY → busy for 16 cycles, MR=0xFFFE, BR=0x0001, C=V=1. Changing MBR during the multiply does not alter the result.
- i_rst asserted during RD wait → next edge: o_mem_rd=0, o_busy=0, MBR=0. A later ack is ignored. i_halt=1 → o_ir_opcode=0x00.

Source files
------------

// File: rtl/reg_datapath_param.sv
// reg_datapath_param: parametrised register datapath (PC, MAR, MBR, IR,
// NACC accumulators, registered ALU with iterative multiplier) sitting
// between the control unit and a handshaked external memory bus.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cpu_start         gates the C2 fetch strobe
//   i_ctrl[15:0]        control strobes C0..C15 (bit n = Cn)
//   i_alu_op[3:0]       [3] ALU enable, [2:0] operation
//   i_acc_sel           accumulator select for C9..C12 and the ALU P operand
//   i_halt              forces o_ir_opcode to zero
//   i_mar_inc           MAR increment request
//   i_mem_rdata/ack     memory read data / transaction complete
//   o_mem_addr/wdata    MAR / MBR
//   o_mem_rd/wr         registered read / write requests
//   o_busy              registered stall to the control unit
//   o_ir_opcode         IR opcode field (combinational, halt-masked)
//   o_flags             {memerr, N, V, C, Z}
//   o_alu_p/q/lo/hi     selected ACC, MBR, BR, MR
module reg_datapath_param #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned OPC_W       = 8,
  parameter int unsigned NACC        = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  localparam int unsigned AW         = (NACC > 1) ? $clog2(NACC) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_start,
  input  logic [15:0]       i_ctrl,
  input  logic [3:0]        i_alu_op,
  input  logic [AW-1:0]     i_acc_sel,
  input  logic              i_halt,
  input  logic              i_mar_inc,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic              o_busy,
  output logic [OPC_W-1:0]  o_ir_opcode,
  output logic [4:0]        o_flags,
  output logic [DATA_W-1:0] o_alu_p,
  output logic [DATA_W-1:0] o_alu_q,
  output logic [DATA_W-1:0] o_alu_lo,
  output logic [DATA_W-1:0] o_alu_hi
);

  localparam int unsigned TW  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned MW  = $clog2(DATA_W + 1);
  localparam int unsigned MSB = DATA_W - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MPY = 3'd7;

  logic [ADDR_W-1:0]   pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0]   mbr_q, mbr_d, ir_q, ir_d, br_q, br_d, mr_q, mr_d;
  logic [DATA_W-1:0]   acc_q [NACC];
  logic [DATA_W-1:0]   acc_d [NACC];
  logic [4:0]          flags_q, flags_d;
  logic [1:0]          state_q, state_d;
  logic [TW-1:0]       wcnt_q, wcnt_d;
  logic                rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;
  logic                mul_active_q, mul_active_d;
  logic [MW-1:0]       mul_cnt_q, mul_cnt_d;
  logic [DATA_W-1:0]   mul_mcand_q, mul_mcand_d;
  logic [2*DATA_W-1:0] mul_prod_q, mul_prod_d;

  logic [15:0]         ctrl_c;
  logic                fetch_c, alu_en_c, mar_inc_c;
  logic                rd_done_c, timeout_c;
  logic [DATA_W-1:0]   p_c, res_c;
  logic [DATA_W:0]     sum_c, dif_c, mul_sum_c;
  logic [2*DATA_W-1:0] mul_next_c;
  logic                cout_c, ovf_c;
  logic                unused_c;

  // Control inputs are only honoured while the datapath is not stalled.
  always_comb begin : strobe_gate
    ctrl_c    = busy_q ? 16'h0000 : i_ctrl;
    fetch_c   = ctrl_c[2] & i_cpu_start;
    alu_en_c  = ~busy_q & i_alu_op[3];
    mar_inc_c = ~busy_q & i_mar_inc;
  end

  // ALU P operand mux; out-of-range selects fall back to ACC0.
  always_comb begin : p_mux
    p_c = acc_q[0];
    for (int unsigned i = 1; i < NACC; i++) begin
      if (i_acc_sel == AW'(i)) p_c = acc_q[i];
    end
  end

  // Memory handshake FSM with wait-cycle timeout.
  always_comb begin : mem_fsm
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rd_done_c = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wcnt_d = '0;
        if (ctrl_c[5])       state_d = ST_RD;
        else if (ctrl_c[13]) state_d = ST_WR;
      end
      ST_RD, ST_WR: begin
        if (i_mem_ack) begin
          state_d   = ST_IDLE;
          wcnt_d    = '0;
          rd_done_c = (state_q == ST_RD);
        end else if (wcnt_q == TW'(MEM_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          wcnt_d    = '0;
          timeout_c = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Single-cycle ALU operations.
  always_comb begin : alu_comb
    sum_c  = {1'b0, p_c} + {1'b0, mbr_q};
    dif_c  = {1'b0, p_c} - {1'b0, mbr_q};
    res_c  = '0;
    cout_c = 1'b0;
    ovf_c  = 1'b0;
    case (i_alu_op[2:0])
      OP_ADD: begin
        res_c  = sum_c[MSB:0];
        cout_c = sum_c[DATA_W];
        ovf_c  = (p_c[MSB] == mbr_q[MSB]) & (res_c[MSB] != p_c[MSB]);
      end
      OP_SUB: begin
        res_c  = dif_c[MSB:0];
        cout_c = dif_c[DATA_W];
        ovf_c  = (p_c[MSB] != mbr_q[MSB]) & (res_c[MSB] != p_c[MSB]);
      end
      OP_AND: res_c = p_c & mbr_q;
      OP_OR:  res_c = p_c | mbr_q;
      OP_NOT: res_c = ~p_c;
      OP_SHL: begin
        res_c  = {p_c[MSB-1:0], 1'b0};
        cout_c = p_c[MSB];
      end
      OP_SHR: begin
        res_c  = {1'b0, p_c[MSB:1]};
        cout_c = p_c[0];
      end
      default: res_c = '0;
    endcase
  end

  // One shift-add step: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole product right.
  always_comb begin : mul_step
    mul_sum_c  = {1'b0, mul_prod_q[2*DATA_W-1:DATA_W]}
               + (mul_prod_q[0] ? {1'b0, mul_mcand_q} : {(DATA_W+1){1'b0}});
    mul_next_c = {mul_sum_c, mul_prod_q[DATA_W-1:1]};
  end

  // Next-state for all datapath registers.
  always_comb begin : datapath_next
    pc_d         = pc_q;
    mar_d        = mar_q;
    mbr_d        = mbr_q;
    ir_d         = ir_q;
    br_d         = br_q;
    mr_d         = mr_q;
    flags_d      = flags_q;
    mul_active_d = mul_active_q;
    mul_cnt_d    = mul_cnt_q;
    mul_mcand_d  = mul_mcand_q;
    mul_prod_d   = mul_prod_q;
    for (int unsigned i = 0; i < NACC; i++) acc_d[i] = acc_q[i];

    if (ctrl_c[3])     pc_d = mbr_q[ADDR_W-1:0];
    else if (fetch_c)  pc_d = pc_q + ADDR_W'(1);

    if (fetch_c)        mar_d = pc_q;
    else if (ctrl_c[8]) mar_d = mbr_q[ADDR_W-1:0];
    else if (mar_inc_c) mar_d = mar_q + ADDR_W'(1);

    if (rd_done_c)       mbr_d = i_mem_rdata;
    else if (ctrl_c[12]) mbr_d = p_c;
    else if (ctrl_c[15]) mbr_d = DATA_W'(ir_q[ADDR_W-1:0]);
    else if (ctrl_c[1])  mbr_d = DATA_W'(pc_q);

    if (ctrl_c[4]) ir_d = mbr_q;

    for (int unsigned i = 0; i < NACC; i++) begin
      if (i_acc_sel == AW'(i)) begin
        if (ctrl_c[11])      acc_d[i] = mbr_q;
        else if (ctrl_c[9])  acc_d[i] = br_q;
        else if (ctrl_c[10]) acc_d[i] = mr_q;
      end
    end

    if (mul_active_q) begin
      mul_prod_d = mul_next_c;
      mul_cnt_d  = mul_cnt_q - MW'(1);
      if (mul_cnt_q == MW'(1)) begin
        mul_active_d = 1'b0;
        br_d         = mul_next_c[DATA_W-1:0];
        mr_d         = mul_next_c[2*DATA_W-1:DATA_W];
        flags_d[0]   = (mul_next_c == '0);
        flags_d[1]   = (mul_next_c[2*DATA_W-1:DATA_W] != '0);
        flags_d[2]   = (mul_next_c[2*DATA_W-1:DATA_W] != '0);
        flags_d[3]   = mul_next_c[2*DATA_W-1];
      end
    end else if (alu_en_c) begin
      if (i_alu_op[2:0] == OP_MPY) begin
        mul_active_d = 1'b1;
        mul_cnt_d    = MW'(DATA_W);
        mul_mcand_d  = p_c;
        mul_prod_d   = {{DATA_W{1'b0}}, mbr_q};
      end else begin
        br_d         = res_c;
        mr_d         = '0;
        flags_d[3:0] = {res_c[MSB], ovf_c, cout_c, (res_c == '0)};
      end
    end

    if (timeout_c) flags_d[4] = 1'b1;

    rd_d   = (state_d == ST_RD);
    wr_d   = (state_d == ST_WR);
    busy_d = (state_d != ST_IDLE) | mul_active_d;
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q         <= '0;
      mar_q        <= '0;
      mbr_q        <= '0;
      ir_q         <= '0;
      br_q         <= '0;
      mr_q         <= '0;
      acc_q        <= '{default: '0};
      flags_q      <= '0;
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      mul_active_q <= 1'b0;
      mul_cnt_q    <= '0;
      mul_mcand_q  <= '0;
      mul_prod_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      mar_q        <= mar_d;
      mbr_q        <= mbr_d;
      ir_q         <= ir_d;
      br_q         <= br_d;
      mr_q         <= mr_d;
      acc_q        <= acc_d;
      flags_q      <= flags_d;
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
      mul_active_q <= mul_active_d;
      mul_cnt_q    <= mul_cnt_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_prod_q   <= mul_prod_d;
    end
  end

  assign o_mem_addr  = mar_q;
  assign o_mem_wdata = mbr_q;
  assign o_mem_rd    = rd_q;
  assign o_mem_wr    = wr_q;
  assign o_busy      = busy_q;
  assign o_ir_opcode = i_halt ? '0 : ir_q[DATA_W-1 -: OPC_W];
  assign o_flags     = flags_q;
  assign o_alu_p     = p_c;
  assign o_alu_q     = mbr_q;
  assign o_alu_lo    = br_q;
  assign o_alu_hi    = mr_q;

  // C0, C6, C7 and C14 carry no datapath action; IR middle bits may be unused.
  assign unused_c = ^{i_ctrl[0], i_ctrl[6], i_ctrl[7], i_ctrl[14], ir_q};

endmodule

// File: tb/tb_reg_datapath_param.sv
// Self-checking bench for reg_datapath_param with default parameters.
module tb_reg_datapath_param;

  localparam int unsigned DW = 16;
  localparam int unsigned AWD = 8;

  logic          i_clk = 1'b0;
  logic          i_rst, i_cpu_start, i_halt, i_mar_inc, i_mem_ack;
  logic [15:0]   i_ctrl;
  logic [3:0]    i_alu_op;
  logic [1:0]    i_acc_sel;
  logic [DW-1:0] i_mem_rdata;
  logic [AWD-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata, o_alu_p, o_alu_q, o_alu_lo, o_alu_hi;
  logic          o_mem_rd, o_mem_wr, o_busy;
  logic [7:0]    o_ir_opcode;
  logic [4:0]    o_flags;

  reg_datapath_param dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cpu_start(i_cpu_start), .i_ctrl(i_ctrl),
    .i_alu_op(i_alu_op), .i_acc_sel(i_acc_sel), .i_halt(i_halt),
    .i_mar_inc(i_mar_inc), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_rd(o_mem_rd),
    .o_mem_wr(o_mem_wr), .o_busy(o_busy), .o_ir_opcode(o_ir_opcode),
    .o_flags(o_flags), .o_alu_p(o_alu_p), .o_alu_q(o_alu_q),
    .o_alu_lo(o_alu_lo), .o_alu_hi(o_alu_hi)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", got, ~got);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ctrl    = 16'h0000;
    i_alu_op  = 4'h0;
    i_mar_inc = 1'b0;
    i_mem_ack = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] ctrl, input logic [3:0] op, input logic [1:0] sel);
    i_ctrl    = ctrl;
    i_alu_op  = op;
    i_acc_sel = sel;
    tick();
    idle_inputs();
  endtask

  // Launch a read and acknowledge it in the n-th wait cycle.
  task automatic do_read(input logic [DW-1:0] data, input int n);
    strobe(16'h0020, 4'h0, i_acc_sel);
    for (int k = 1; k < n; k++) tick();
    i_mem_rdata = data;
    i_mem_ack   = 1'b1;
    tick();
    i_mem_ack   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt, wr_cnt, busy_cnt;
    logic busy_before;

    idle_inputs();
    i_rst = 1'b1; i_cpu_start = 1'b0; i_halt = 1'b0;
    i_acc_sel = 2'd0; i_mem_rdata = '0;
    tick(); tick();
    i_rst = 1'b0;

    // Reset state
    sb_push("rst_addr", 32'h0); sb_push("rst_wdata", 32'h0);
    sb_push("rst_rd", 32'h0);   sb_push("rst_wr", 32'h0);
    sb_push("rst_busy", 32'h0); sb_push("rst_flags", 32'h0);
    sb_push("rst_lo", 32'h0);   sb_push("rst_hi", 32'h0);
    sb_pop(32'(o_mem_addr)); sb_pop(32'(o_mem_wdata));
    sb_pop(32'(o_mem_rd));   sb_pop(32'(o_mem_wr));
    sb_pop(32'(o_busy));     sb_pop(32'(o_flags));
    sb_pop(32'(o_alu_lo));   sb_pop(32'(o_alu_hi));

    // PC wrap through fetch
    do_read(16'h00FF, 1);
    strobe(16'h0008, 4'h0, 2'd0);           // C3: PC <= 0xFF
    i_cpu_start = 1'b1;
    sb_push("fetch_mar", 32'hFF);
    strobe(16'h0004, 4'h0, 2'd0);           // C2
    sb_pop(32'(o_mem_addr));
    sb_push("fetch_pc_wrap", 32'h0000);
    strobe(16'h0002, 4'h0, 2'd0);           // C1: MBR <= PC
    sb_pop(32'(o_mem_wdata));
    i_cpu_start = 1'b0;
    sb_push("fetch_gated", 32'hFF);
    strobe(16'h0004, 4'h0, 2'd0);
    sb_pop(32'(o_mem_addr));

    // Read with 3-cycle wait; C8 and MAR increment during the wait are ignored
    do_read(16'h0010, 1);
    strobe(16'h0100, 4'h0, 2'd0);           // C8: MAR <= 0x10
    strobe(16'h0002, 4'h0, 2'd0);           // MBR <= PC (0)
    sb_push("rd_rd_cycles", 32'd3); sb_push("rd_busy_before", 32'd1);
    sb_push("rd_busy_after", 32'd0); sb_push("rd_req_after", 32'd0);
    sb_push("rd_mbr", 32'hBEEF);     sb_push("rd_mar_held", 32'h10);
    strobe(16'h0020, 4'h0, 2'd0);
    rd_cnt = 0; busy_before = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      i_ctrl = 16'h0100; i_mar_inc = 1'b1;
      i_mem_ack = (c == 3); i_mem_rdata = 16'hBEEF;
      if (o_mem_rd) rd_cnt++;
      if (c == 3) busy_before = o_busy;
      tick();
    end
    idle_inputs();
    sb_pop(32'(rd_cnt)); sb_pop(32'(busy_before));
    sb_pop(32'(o_busy)); sb_pop(32'(o_mem_rd));
    sb_pop(32'(o_mem_wdata)); sb_pop(32'(o_mem_addr));

    // Write timeout sets sticky memerr
    sb_push("wr_cycles", 32'd15); sb_push("wr_memerr", 32'd1);
    sb_push("wr_busy_after", 32'd0);
    strobe(16'h2000, 4'h0, 2'd0);
    wr_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (o_mem_wr) wr_cnt++;
      tick();
    end
    sb_pop(32'(wr_cnt)); sb_pop(32'(o_flags[4])); sb_pop(32'(o_busy));
    sb_push("memerr_sticky", 32'd1);
    do_read(16'h7FFF, 2);
    sb_pop(32'(o_flags[4]));

    // ADD overflow into ACC1, then C9 write-back
    strobe(16'h0800, 4'h0, 2'd1);           // ACC1 <= 0x7FFF
    do_read(16'h0001, 1);
    sb_push("add_br", 32'h8000); sb_push("add_mr", 32'h0);
    sb_push("add_flags", 32'b11100);
    strobe(16'h0000, 4'b1000, 2'd1);
    sb_pop(32'(o_alu_lo)); sb_pop(32'(o_alu_hi)); sb_pop(32'(o_flags));
    sb_push("c9_acc1", 32'h8000); sb_push("c9_acc0", 32'h0000);
    strobe(16'h0200, 4'h0, 2'd1);
    i_acc_sel = 2'd1; #1 sb_pop(32'(o_alu_p));
    i_acc_sel = 2'd0; #1 sb_pop(32'(o_alu_p));

    // SUB overflow, SUB borrow, disabled ALU hold, SHL carry-out
    sb_push("sub_ovf_br", 32'h7FFF); sb_push("sub_ovf_flags", 32'b10100);
    strobe(16'h0000, 4'b1001, 2'd1);
    sb_pop(32'(o_alu_lo)); sb_pop(32'(o_flags));
    sb_push("sub_brw_br", 32'hFFFF); sb_push("sub_brw_flags", 32'b11010);
    strobe(16'h0000, 4'b1001, 2'd0);
    sb_pop(32'(o_alu_lo)); sb_pop(32'(o_flags));
    sb_push("hold_br", 32'hFFFF); sb_push("hold_flags", 32'b11010);
    strobe(16'h0000, 4'b0000, 2'd0);
    sb_pop(32'(o_alu_lo)); sb_pop(32'(o_flags));
    sb_push("shl_br", 32'h0000); sb_push("shl_flags", 32'b10011);
    strobe(16'h0000, 4'b1101, 2'd1);
    sb_pop(32'(o_alu_lo)); sb_pop(32'(o_flags));

    // MPY 0xFFFF*0xFFFF; a read launched alongside rewrites MBR mid-multiply
    do_read(16'hFFFF, 1);
    strobe(16'h0800, 4'h0, 2'd0);           // ACC0 <= 0xFFFF
    sb_push("mpy_busy_cycles", 32'd16); sb_push("mpy_mr", 32'hFFFE);
    sb_push("mpy_br", 32'h0001); sb_push("mpy_flags", 32'b11110);
    sb_push("mpy_mbr_changed", 32'h0003);
    strobe(16'h0020, 4'b1111, 2'd0);
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!o_busy) break;
      busy_cnt++;
      i_mem_ack = (c == 2); i_mem_rdata = 16'h0003;
      tick();
    end
    i_mem_ack = 1'b0;
    sb_pop(32'(busy_cnt)); sb_pop(32'(o_alu_hi)); sb_pop(32'(o_alu_lo));
    sb_pop(32'(o_flags));  sb_pop(32'(o_mem_wdata));

    // Reset during read wait, then a stray ack
    sb_push("rstmid_rd", 32'd0); sb_push("rstmid_busy", 32'd0);
    sb_push("rstmid_mbr", 32'h0); sb_push("rstmid_flags", 32'h0);
    strobe(16'h0020, 4'h0, 2'd0);
    tick();
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    sb_pop(32'(o_mem_rd)); sb_pop(32'(o_busy));
    sb_pop(32'(o_mem_wdata)); sb_pop(32'(o_flags));
    sb_push("idle_ack_mbr", 32'h0); sb_push("idle_ack_busy", 32'd0);
    i_mem_rdata = 16'h1234; i_mem_ack = 1'b1; tick(); i_mem_ack = 1'b0;
    sb_pop(32'(o_mem_wdata)); sb_pop(32'(o_busy));

    // IR opcode and halt masking
    do_read(16'hA5C3, 1);
    strobe(16'h0010, 4'h0, 2'd0);           // C4: IR <= MBR
    sb_push("opcode", 32'hA5); sb_push("opcode_halt", 32'h00);
    i_halt = 1'b0; #1 sb_pop(32'(o_ir_opcode));
    i_halt = 1'b1; #1 sb_pop(32'(o_ir_opcode));
    i_halt = 1'b0;

    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
